alu_ex_stage: RTL and testbench
===============================

# alu_ex_stage

Registered execute stage that accepts decoded ALU operations over a valid/ready handshake and drives the combinational `ALU` with them. It captures `alu_res` into an output pipeline register backed by a one-entry skid buffer, so `in_ready` is a registered signal. It sits between the decode/operand-fetch stage upstream and writeback downstream, and is the only instantiator of `ALU`.

## Interface
- `DW`, 32: operand and result width.
- `OPW`, 5: ALU op width; must match `ALU`'s `alu_op`.
- `RW`, 5: destination register tag width.
- `clk`  input  1  rising-edge clock.
- `rstn`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  upstream holds a valid op.
- `in_ready`  output  1  stage can accept; registered.
- `in_src0`, `in_src1`  input  DW  operands, routed to `alu_src0` and `alu_src1`.
- `in_op`  input  OPW  routed to `alu_op`.
- `in_rd`  input  RW  destination tag, carried alongside the result.
- `out_valid`  output  1  result available.
- `out_ready`  input  1  downstream accepts.
- `out_res`  output  DW  registered ALU result.
- `out_rd`  output  RW  tag matching `out_res`.
- `perf_cnt`  output  32  retired-op count; exists only with the macro defined.

## Operation
- Storage: a main register `{valid, res, rd}` drives the outputs directly; a skid register has the same fields.
- `ALU` is combinational on the `in_*` fields. A transfer occurs when `in_valid && in_ready`.
- Accept: `in_fire = in_valid && in_ready`. Retire: `out_fire = out_valid && out_ready`.
- Each cycle, by case:
  - Main empty, or `out_fire`: main loads from the skid if the skid is valid (skid clears). Otherwise main loads the fresh ALU result if `in_fire`. Otherwise main goes invalid.
  - Skid valid and `out_fire` and `in_fire` in the same cycle: not possible, because `in_ready` is 0 while the skid is full.
  - Main full and not `out_fire` and `in_fire`: the fresh result goes into the skid.
- `in_ready = !skid_valid`, taken from a flop. Total capacity is 2 ops.
- Ordering is strict FIFO; no op is reordered or dropped.
- `out_res` and `out_rd` hold stable while `out_valid && !out_ready`. This is a handshake rule that assertions check.
- Arithmetic belongs entirely to `ALU`. The stage does not inspect `in_op`. An illegal op passes through whatever `ALU` produces.

## Timing
- Reset while `rstn` is low, asynchronous:
  - `out_valid=0`, `out_res=0`, `out_rd=0`
  - skid invalid, `in_ready=1`
  - `perf_cnt=0`
- Latency is 1 cycle: an op accepted at edge N appears on `out_*` after edge N when the stage was empty.
- Throughput is 1 op/cycle while `out_ready` stays high.
- Backpressure:
  - `out_ready` low with main full: the next accepted op fills the skid.
  - `in_ready` falls on the following edge.
  - It rises again on the edge after the skid drains into main.
- Simultaneous accept and retire with skid empty: main is replaced by the new result with no bubble.
- A reset asserted mid-stream discards both entries at once; there is no partial drain.
- No combinational path exists from `out_ready` to `in_ready`.

## Configuration
- `ALU_EX_PERF_EN` defined:
  - `perf_cnt` port present.
  - Increments by 1 on every `out_fire` and wraps from 32'hFFFFFFFF to 0.
- Undefined: port and counter are absent. Datapath behaviour is identical.

## Structure
- Shared package `alu_pkg` holds `DW`/`OPW` defaults and the `alu_op` encoding constants, with `ALU_ADD=5'd1`. `ALU` and this stage both import them.
- One sub-module, `ALU`, is instantiated as-is. The skid logic stays inline.

## Test plan
- Single op: `src0=32'h8000ffff`, `src1=1`, `op=ALU_ADD`, `rd=3`, `out_ready=1` -> next cycle `out_valid=1`, `out_res=32'h80010000`, `out_rd=3`.
- Streaming: 32 back-to-back ops with `op` 0..31 and `out_ready=1` -> 32 consecutive `out_valid` cycles, in order, each `out_res` matching a reference model of `ALU`.
- Backpressure: `out_ready=0` with 3 ops offered -> 2 accepted, `in_ready=0` from the cycle after the second. Raising `out_ready` -> both retire in order, then the third is accepted.
- Stability: `out_ready` toggled randomly for 1000 ops -> `out_res`/`out_rd` never change while stalled, and there is no loss or duplication.
- Reset mid-operation: both entries full, `rstn` pulsed low -> `out_valid=0`, `in_ready=1`, `out_res=0` immediately, and nothing retires afterward.
- With `ALU_EX_PERF_EN`: 5 retires -> `perf_cnt=5`. Force the counter to 32'hFFFFFFFF, retire one -> 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: default widths and the alu_op encoding.
// Used by both ALU and alu_ex_stage.
package alu_pkg;

    localparam int ALU_DW  = 32;
    localparam int ALU_OPW = 5;

    // Encodings not listed here are illegal; ALU returns zero for them.
    localparam logic [ALU_OPW-1:0] ALU_NOP  = 5'd0;
    localparam logic [ALU_OPW-1:0] ALU_ADD  = 5'd1;
    localparam logic [ALU_OPW-1:0] ALU_SUB  = 5'd2;
    localparam logic [ALU_OPW-1:0] ALU_AND  = 5'd3;
    localparam logic [ALU_OPW-1:0] ALU_OR   = 5'd4;
    localparam logic [ALU_OPW-1:0] ALU_XOR  = 5'd5;
    localparam logic [ALU_OPW-1:0] ALU_SLL  = 5'd6;
    localparam logic [ALU_OPW-1:0] ALU_SRL  = 5'd7;
    localparam logic [ALU_OPW-1:0] ALU_SRA  = 5'd8;
    localparam logic [ALU_OPW-1:0] ALU_SLT  = 5'd9;
    localparam logic [ALU_OPW-1:0] ALU_SLTU = 5'd10;
    localparam logic [ALU_OPW-1:0] ALU_PSA  = 5'd11;
    localparam logic [ALU_OPW-1:0] ALU_PSB  = 5'd12;

endpackage

// File: rtl/ALU.sv
// Purely combinational ALU. Shift amount is the low log2(DW) bits of src1.
// NOP and illegal encodings yield zero.
import alu_pkg::*;

module ALU #(
    parameter int DW  = ALU_DW,
    parameter int OPW = ALU_OPW
) (
    input  logic [DW-1:0]  alu_src0,
    input  logic [DW-1:0]  alu_src1,
    input  logic [OPW-1:0] alu_op,
    output logic [DW-1:0]  alu_res
);

    localparam int SHW = $clog2(DW);

    logic [SHW-1:0] w_shamt;
    assign w_shamt = alu_src1[SHW-1:0];

    // Operation decode; result defaults to zero for anything unrecognised.
    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_ADD:  alu_res = alu_src0 + alu_src1;
            ALU_SUB:  alu_res = alu_src0 - alu_src1;
            ALU_AND:  alu_res = alu_src0 & alu_src1;
            ALU_OR:   alu_res = alu_src0 | alu_src1;
            ALU_XOR:  alu_res = alu_src0 ^ alu_src1;
            ALU_SLL:  alu_res = alu_src0 << w_shamt;
            ALU_SRL:  alu_res = alu_src0 >> w_shamt;
            ALU_SRA:  alu_res = $unsigned($signed(alu_src0) >>> w_shamt);
            ALU_SLT:  alu_res = {{(DW-1){1'b0}}, $signed(alu_src0) < $signed(alu_src1)};
            ALU_SLTU: alu_res = {{(DW-1){1'b0}}, alu_src0 < alu_src1};
            ALU_PSA:  alu_res = alu_src0;
            ALU_PSB:  alu_res = alu_src1;
            default:  alu_res = '0;
        endcase
    end

endmodule

// File: rtl/alu_ex_stage.sv
// Registered ALU execute stage: main output register plus a one-entry skid
// buffer, so in_ready comes straight from a flop (no out_ready->in_ready path).
// Optional retired-op counter on port perf_cnt when ALU_EX_PERF_EN is defined.
import alu_pkg::*;

module alu_ex_stage #(
    parameter int DW  = ALU_DW,
    parameter int OPW = ALU_OPW,
    parameter int RW  = 5
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [DW-1:0]  in_src0,
    input  logic [DW-1:0]  in_src1,
    input  logic [OPW-1:0] in_op,
    input  logic [RW-1:0]  in_rd,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [DW-1:0]  out_res,
    output logic [RW-1:0]  out_rd
`ifdef ALU_EX_PERF_EN
    ,
    output logic [31:0]    perf_cnt
`endif
);

    logic           r_main_vld;
    logic [DW-1:0]  r_main_res;
    logic [RW-1:0]  r_main_rd;
    logic           r_skid_vld;
    logic [DW-1:0]  r_skid_res;
    logic [RW-1:0]  r_skid_rd;

    logic [DW-1:0]  w_alu_res;
    logic           w_in_fire;
    logic           w_out_fire;

    ALU #(.DW(DW), .OPW(OPW)) u_alu (
        .alu_src0 (in_src0),
        .alu_src1 (in_src1),
        .alu_op   (in_op),
        .alu_res  (w_alu_res)
    );

    // in_ready is the inverted skid flop: accept only while the skid has room.
    assign in_ready   = !r_skid_vld;
    assign w_in_fire  = in_valid && !r_skid_vld;
    assign w_out_fire = r_main_vld && out_ready;

    assign out_valid = r_main_vld;
    assign out_res   = r_main_res;
    assign out_rd    = r_main_rd;

    // Main/skid update: main refills from skid first (keeps FIFO order), else
    // from the ALU; a result arriving while main is stalled parks in the skid.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_main_vld <= 1'b0;
            r_main_res <= '0;
            r_main_rd  <= '0;
            r_skid_vld <= 1'b0;
            r_skid_res <= '0;
            r_skid_rd  <= '0;
        end else if (!r_main_vld || w_out_fire) begin
            if (r_skid_vld) begin
                // in_ready is low here, so no new op can collide with the drain
                r_main_vld <= 1'b1;
                r_main_res <= r_skid_res;
                r_main_rd  <= r_skid_rd;
                r_skid_vld <= 1'b0;
            end else if (w_in_fire) begin
                r_main_vld <= 1'b1;
                r_main_res <= w_alu_res;
                r_main_rd  <= in_rd;
            end else begin
                r_main_vld <= 1'b0;
            end
        end else if (w_in_fire) begin
            r_skid_vld <= 1'b1;
            r_skid_res <= w_alu_res;
            r_skid_rd  <= in_rd;
        end
    end

`ifdef ALU_EX_PERF_EN
    logic [31:0] r_perf_cnt;

    // Retired-op counter; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)           r_perf_cnt <= '0;
        else if (w_out_fire) r_perf_cnt <= r_perf_cnt + 32'd1;
    end

    assign perf_cnt = r_perf_cnt;
`endif

endmodule

// File: tb/tb_alu_ex_stage.sv
// Bench for alu_ex_stage: directed vector table, streaming, backpressure,
// random stall stability, mid-stream reset, and (with ALU_EX_PERF_EN) the
// retire counter. A scoreboard queue tracks every accepted op.
import alu_pkg::*;

module tb_alu_ex_stage;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_src0 = '0;
    logic [31:0] in_src1 = '0;
    logic [4:0]  in_op = '0;
    logic [4:0]  in_rd = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_res;
    logic [4:0]  out_rd;
`ifdef ALU_EX_PERF_EN
    logic [31:0] perf_cnt;
`endif

    alu_ex_stage dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_src0   (in_src0),
        .in_src1   (in_src1),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_rd    (out_rd)
`ifdef ALU_EX_PERF_EN
        ,
        .perf_cnt  (perf_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  op;
        logic [4:0]  rd;
        logic [31:0] res;
    } vec_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   n_acc = 0;
    int   n_ret = 0;

    // Independent reference: subtraction via two's complement, signed compare
    // via sign bits, arithmetic shift via a 64-bit sign-extended shift.
    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] op);
        logic [63:0] ext;
        int          s;
        s   = int'(b[4:0]);
        ext = {{32{a[31]}}, a} >> s;
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a + ~b + 32'd1;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLL:  return a << s;
            ALU_SRL:  return a >> s;
            ALU_SRA:  return ext[31:0];
            ALU_SLT:  return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
            ALU_SLTU: return {31'd0, a < b};
            ALU_PSA:  return a;
            ALU_PSB:  return b;
            default:  return 32'd0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pop/compare on retire, push on accept, and hold-stable check
    // for any cycle following a stall.
    initial begin
        logic        prev_stall;
        logic [31:0] prev_res;
        logic [4:0]  prev_rd;
        exp_t        e;
        prev_stall = 1'b0;
        prev_res   = '0;
        prev_rd    = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", {31'd0, out_valid}, 32'd1);
                    chk("stall_res", out_res, prev_res);
                    chk("stall_rd", {27'd0, out_rd}, {27'd0, prev_rd});
                end
                if (out_valid && out_ready) begin
                    n_ret++;
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_retire: got res %h rd %0d, expected none", out_res, out_rd);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_res", out_res, e.res);
                        chk("sb_rd", {27'd0, out_rd}, {27'd0, e.rd});
                    end
                end
                if (in_valid && in_ready) begin
                    e.res = ref_alu(in_src0, in_src1, in_op);
                    e.rd  = in_rd;
                    sb.push_back(e);
                    n_acc++;
                end
                prev_stall = out_valid && !out_ready;
                prev_res   = out_res;
                prev_rd    = out_rd;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic put(input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] op, input logic [4:0] rd);
        in_valid = 1'b1;
        in_src0  = a;
        in_src1  = b;
        in_op    = op;
        in_rd    = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vt[13];

    initial begin
        int cnt;
        int cyc;
        logic fire;

        vt[0]  = '{32'h8000ffff, 32'h00000001, ALU_ADD,  5'd3,  32'h80010000};
        vt[1]  = '{32'hffffffff, 32'h00000001, ALU_ADD,  5'd1,  32'h00000000};
        vt[2]  = '{32'h00000000, 32'h00000001, ALU_SUB,  5'd2,  32'hffffffff};
        vt[3]  = '{32'hf0f0f0f0, 32'hff00ff00, ALU_AND,  5'd4,  32'hf000f000};
        vt[4]  = '{32'h0f0f0000, 32'h000000ff, ALU_OR,   5'd5,  32'h0f0f00ff};
        vt[5]  = '{32'haaaaaaaa, 32'hffffffff, ALU_XOR,  5'd6,  32'h55555555};
        vt[6]  = '{32'h00000001, 32'h0000001f, ALU_SLL,  5'd7,  32'h80000000};
        vt[7]  = '{32'h80000000, 32'h00000024, ALU_SRL,  5'd8,  32'h08000000};
        vt[8]  = '{32'h80000000, 32'h00000004, ALU_SRA,  5'd9,  32'hf8000000};
        vt[9]  = '{32'hffffffff, 32'h00000001, ALU_SLT,  5'd10, 32'h00000001};
        vt[10] = '{32'hffffffff, 32'h00000001, ALU_SLTU, 5'd11, 32'h00000000};
        vt[11] = '{32'h00000000, 32'h12345678, ALU_PSB,  5'd12, 32'h12345678};
        vt[12] = '{32'hdeadbeef, 32'h12345678, 5'd31,    5'd31, 32'h00000000};

        // Reset state
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_res", out_res, 32'd0);
        chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
        step();
        step();
        rstn = 1'b1;
        out_ready = 1'b1;
        step();

        // Directed vectors, one op each, checked one cycle after acceptance
        for (int i = 0; i < 13; i++) begin
            put(vt[i].a, vt[i].b, vt[i].op, vt[i].rd);
            step();
            in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("vec%0d_res", i), out_res, vt[i].res);
            chk($sformatf("vec%0d_rd", i), {27'd0, out_rd}, {27'd0, vt[i].rd});
        end
        step();

        // Streaming: 32 back-to-back ops, every op code
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            put($urandom, $urandom, 5'(i), 5'(i));
            step();
            if (out_valid) cnt++;
        end
        in_valid = 1'b0;
        chk("stream_valid_cycles", cnt, 32);
        step();
        chk("stream_drained", {31'd0, out_valid}, 32'd0);

        // Backpressure: A fills main, B fills skid, C must wait
        out_ready = 1'b0;
        put(32'd10, 32'd5, ALU_ADD, 5'd7);
        step();
        chk("bp_A_res", out_res, 32'd15);
        chk("bp_ready_after_A", {31'd0, in_ready}, 32'd1);
        put(32'd100, 32'd1, ALU_SUB, 5'd8);
        step();
        chk("bp_ready_after_B", {31'd0, in_ready}, 32'd0);
        chk("bp_hold_A", out_res, 32'd15);
        put(32'd3, 32'd1, ALU_XOR, 5'd9);
        step();
        chk("bp_ready_still_low", {31'd0, in_ready}, 32'd0);
        chk("bp_hold_A2", {27'd0, out_rd}, 32'd7);
        out_ready = 1'b1;
        step();
        chk("bp_B_res", out_res, 32'd99);
        chk("bp_B_rd", {27'd0, out_rd}, 32'd8);
        chk("bp_ready_back", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp_C_res", out_res, 32'd2);
        chk("bp_C_rd", {27'd0, out_rd}, 32'd9);
        step();
        chk("bp_empty", {31'd0, out_valid}, 32'd0);

        // Random out_ready over 1000 accepted ops
        cnt = 0;
        cyc = 0;
        put($urandom, $urandom, 5'($urandom_range(0, 31)), 5'($urandom));
        while (cnt < 1000 && cyc < 20000) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            fire = in_valid && in_ready;
            step();
            cyc++;
            if (fire) begin
                cnt++;
                put($urandom, $urandom, 5'($urandom_range(0, 31)), 5'($urandom));
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("rand_accepted", cnt, 1000);
        for (int i = 0; i < 10 && sb.size() != 0; i++) step();
        step();
        chk("rand_sb_empty", sb.size(), 0);
        chk("rand_acc_eq_ret", n_acc, n_ret);

        // Reset with both entries full
        out_ready = 1'b0;
        put(32'h11, 32'h22, ALU_ADD, 5'd1);
        step();
        put(32'h33, 32'h44, ALU_ADD, 5'd2);
        step();
        in_valid = 1'b0;
        chk("mid_skid_full", {31'd0, in_ready}, 32'd0);
        #2;
        rstn = 1'b0;
        #1;
        sb.delete();
        chk("mid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_out_res", out_res, 32'd0);
        step();
        rstn = 1'b1;
        out_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (out_valid) cnt++;
        end
        chk("mid_no_retire", cnt, 0);

`ifdef ALU_EX_PERF_EN
        chk("perf_after_reset", perf_cnt, 32'd0);
        for (int i = 0; i < 5; i++) begin
            put(32'(i), 32'd1, ALU_ADD, 5'(i));
            step();
        end
        in_valid = 1'b0;
        step();
        chk("perf_five", perf_cnt, 32'd5);
        @(negedge clk);
        force dut.r_perf_cnt = 32'hFFFFFFFF;
        #1;
        release dut.r_perf_cnt;
        chk("perf_forced", perf_cnt, 32'hFFFFFFFF);
        step();
        put(32'd1, 32'd1, ALU_ADD, 5'd1);
        step();
        in_valid = 1'b0;
        step();
        chk("perf_wrap", perf_cnt, 32'd0);
`endif

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
